mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative MIPS multiply/divide unit holding the architectural HI/LO registers. It sits directly downstream of the register file and consumes its rs/rt read data for MULT, MULTU, DIV and DIVU. Its HI/LO outputs feed the write-data mux for MFHI/MFLO. Control stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and >= 4

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch operation selected by op; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
operand_a  input  WIDTH  rs value (multiplicand / dividend)
operand_b  input  WIDTH  rt value (multiplier / divisor)
hi_write_en  input  1  MTHI: load HI from operand_a
lo_write_en  input  1  MTLO: load LO from operand_a
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO updated on the same edge

Behaviour:
- Reset (synchronous, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0. Applies mid-operation: the partial result is discarded and HI/LO clear to 0.
- FSM states:
  - IDLE -> CALC on start.
  - CALC runs WIDTH iterations (one per cycle) -> FIX.
  - FIX -> IDLE.
- On the start edge: latch op, latch operand magnitudes (absolute values for signed ops), record result signs, clear the iteration counter. busy=1 from this edge.
- CALC, multiply: radix-2 shift-add on the 2*WIDTH accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- FIX:
  - Apply sign correction.
  - Write hi/lo.
  - done=1 for exactly one cycle.
  - busy=0 on the same edge.
- Latency: start at edge 0 -> hi/lo/done at edge WIDTH+1. busy is high for WIDTH+1 cycles (33 at default).
- Signed multiply: full 2*WIDTH two's-complement product. hi={upper}, lo={lower}.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): lo=all ones, hi=operand_a as sampled. Takes full latency; no exception.
- DIV of most-negative by -1: lo=most-negative (0x80000000), hi=0.
- start while busy: ignored, with no effect on the running operation.
- hi_write_en/lo_write_en:
  - Honoured only in IDLE with start=0; ignored while busy.
  - Write takes effect next edge and does not assert done.
  - Both may be set in the same cycle.
- start and hi/lo_write_en in the same IDLE cycle: start wins; the MT writes are dropped.
- start sampled on the same edge that done pulses: not possible, since FIX returns to IDLE first. The earliest new start is the cycle after done.
- hi/lo hold their value throughout CALC. Intermediate values are never visible.
- operand_a/operand_b may change after the start edge without affecting the result.

Optional Feature:
FAST_MULT_EN: when defined, MULT/MULTU compute combinationally and write hi/lo with done=1 on the edge after start, with busy high for that one cycle. DIV/DIVU are unchanged. When undefined, all ops use the iterative WIDTH+1 latency described above.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high exactly 33 cycles.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 in IDLE -> hi=0x1234, lo=0x5678, done stays 0. Repeat both while busy -> hi/lo unchanged.
- Reset at cycle 10 of a DIV -> next cycle hi=lo=0, busy=0. A new start then completes normally. A second start mid-operation -> ignored, original result intact.

Source files
------------

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// It takes the rs/rt read data straight from the register file for
// MULT/MULTU/DIV/DIVU, and HI/LO feed the write-data mux for MFHI/MFLO.
// Control holds the PC while busy is high.
//
// Operation: a start in IDLE latches the operand magnitudes and the result
// signs, then CALC runs WIDTH single-bit iterations (shift-add multiply or
// restoring divide) on one shared 2*WIDTH accumulator. FIX applies the sign
// correction, writes HI/LO and pulses done. Start at edge 0 gives HI/LO/done
// at edge WIDTH+1, with busy high for WIDTH+1 cycles.
//
// Optional build macro:
//   FAST_MULT_EN - MULT/MULTU are computed combinationally at the start edge
//                  and complete on the next edge (busy high for one cycle).
//                  DIV/DIVU keep the iterative latency.
//
// Parameters:
//   WIDTH        operand and HI/LO width (even, >= 4), default 32
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   start        launch the operation selected by op (only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a    rs value (multiplicand / dividend, MTHI/MTLO source)
//   operand_b    rt value (multiplier / divisor)
//   hi_write_en  MTHI: load HI from operand_a (IDLE, no start)
//   lo_write_en  MTLO: load LO from operand_a (IDLE, no start)
//   hi           HI register (product upper half / remainder)
//   lo           LO register (product lower half / quotient)
//   busy         operation in progress
//   done         one-cycle pulse, HI/LO updated on the same edge
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_write_en,
   input  logic             lo_write_en,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;

   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   dz_hi;
   logic               div_zero;

`ifdef FAST_MULT_EN
   logic [2*WIDTH-1:0] fast_prod;
   logic               fast_mul;
`endif

   // Operand magnitudes at the start edge. Only the signed ops (op[0]==0)
   // look at the sign bits; the most-negative value maps to itself, which
   // is still the correct unsigned magnitude.
   always_comb begin
      sign_a = ~op[0] & operand_a[WIDTH-1];
      sign_b = ~op[0] & operand_b[WIDTH-1];
      abs_a  = sign_a ? (~operand_a + 1'b1) : operand_a;
      abs_b  = sign_b ? (~operand_b + 1'b1) : operand_b;
   end

`ifdef FAST_MULT_EN
   // Single-cycle magnitude product; the sign is fixed up in FIX like the
   // iterative path so both share the same write-back logic.
   always_comb begin
      fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
      fast_mul  = ~op[1];
   end
`endif

   // One shift-add multiply step. The accumulator starts as {0, multiplier};
   // each step adds the multiplicand into the upper half when the current
   // multiplier bit (acc[0]) is set, then shifts the whole thing right,
   // keeping the carry as the new top bit.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
      mul_next = {mul_sum, acc[WIDTH-1:1]};
   end

   // One restoring-divide step. The accumulator is {remainder, dividend};
   // shifting left brings the next dividend bit into the remainder. The
   // remainder is always below the divisor, so the shifted value is below
   // twice the divisor and the difference fits in WIDTH bits when it is
   // non-negative. Quotient bits fill in from the bottom.
   always_comb begin
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_ge    = (div_shift >= {1'b0, mag_b});
      div_diff  = div_shift[WIDTH-1:0] - mag_b;
      div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ge};
   end

   // Sign correction applied on the way out of FIX. Quotient sign is the
   // xor of operand signs, remainder follows the dividend. A zero divisor
   // returns the dividend as it was sampled, rebuilt from its magnitude.
   always_comb begin
      prod_fix = neg_res ? (~acc + 1'b1) : acc;
      quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1)
                         : acc[2*WIDTH-1:WIDTH];
      dz_hi    = neg_rem ? (~mag_a + 1'b1) : mag_a;
      div_zero = (mag_b == {WIDTH{1'b0}});
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A start is only seen in IDLE, so a start while busy
   // never disturbs the running operation.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef FAST_MULT_EN
               state_next = fast_mul ? FIX : CALC;
`else
               state_next = CALC;
`endif
            end
         end
         CALC: begin
            if (count == LAST_ITER) begin
               state_next = FIX;
            end
         end
         FIX: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decoded from state. done is registered in the datapath so it
   // lines up with the HI/LO write.
   always_comb begin
      busy = (state != IDLE);
   end

   // Datapath: operand latch on start, iteration in CALC, result write in
   // FIX, and MTHI/MTLO only in IDLE when no start is requested. HI/LO are
   // never touched during CALC, so partial results stay invisible.
   always_ff @(posedge clock) begin
      if (reset) begin
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         mag_a   <= '0;
         mag_b   <= '0;
         acc     <= '0;
         count   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div  <= op[1];
                  neg_res <= sign_a ^ sign_b;
                  neg_rem <= sign_a;
                  mag_a   <= abs_a;
                  mag_b   <= abs_b;
                  count   <= '0;
                  if (op[1]) begin
                     acc <= {{WIDTH{1'b0}}, abs_a};
                  end else begin
`ifdef FAST_MULT_EN
                     acc <= fast_prod;
`else
                     acc <= {{WIDTH{1'b0}}, abs_b};
`endif
                  end
               end else begin
                  if (hi_write_en) begin
                     hi <= operand_a;
                  end
                  if (lo_write_en) begin
                     lo <= operand_a;
                  end
               end
            end
            CALC: begin
               acc   <= is_div ? div_next : mul_next;
               count <= count + 1'b1;
            end
            FIX: begin
               done <= 1'b1;
               if (!is_div) begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end else if (div_zero) begin
                  hi <= dz_hi;
                  lo <= {WIDTH{1'b1}};
               end else begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed testbench for mult_div_unit at WIDTH=32. Each vector launches an
// operation, then while busy it scrambles the operands, drives MTHI/MTLO and
// a stray start, and watches that HI/LO hold and done stays low. When busy
// drops it checks the busy length, the done pulse and the hand-computed
// HI/LO values. Also covers reset state, MTHI/MTLO in IDLE and a reset in
// the middle of a divide.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        hi_write_en;
   logic        lo_write_en;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int assert_count = 0;
   int fail_count   = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .hi_write_en (hi_write_en),
      .lo_write_en (lo_write_en),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done)
   );

   // 10 ns clock; inputs are driven and outputs sampled on the falling edge.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h",
                  tag, observed, expected);
      end
   endtask

   // Launch one operation and follow it to completion. with_mt also raises
   // MTHI/MTLO in the start cycle; those writes must be dropped.
   task automatic applyStimulus(input string tag, input logic [1:0] o,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic with_mt,
                                input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo);
      logic [31:0] hi0;
      logic [31:0] lo0;
      int          busy_cycles;
      int          exp_len;
      int          done_early;
      logic        hold_bad;

`ifdef FAST_MULT_EN
      exp_len = o[1] ? 33 : 1;
`else
      exp_len = 33;
`endif
      @(negedge clock);
      hi0         = hi;
      lo0         = lo;
      start       = 1'b1;
      op          = o;
      operand_a   = a;
      operand_b   = b;
      hi_write_en = with_mt;
      lo_write_en = with_mt;
      @(posedge clock);
      #1;
      start       = 1'b0;
      hi_write_en = 1'b0;
      lo_write_en = 1'b0;
      busy_cycles = 0;
      done_early  = 0;
      hold_bad    = 1'b0;
      @(negedge clock);
      while (busy && busy_cycles < 100) begin
         busy_cycles++;
         if (done) done_early++;
         if (hi !== hi0 || lo !== lo0) hold_bad = 1'b1;
         start       = (busy_cycles == 5);
         op          = ~o;
         operand_a   = $urandom;
         operand_b   = $urandom;
         hi_write_en = 1'b1;
         lo_write_en = 1'b1;
         @(negedge clock);
      end
      start       = 1'b0;
      hi_write_en = 1'b0;
      lo_write_en = 1'b0;
      checkOutput({tag, "_busy_len"}, 64'(busy_cycles), 64'(exp_len));
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      checkOutput({tag, "_done_early"}, 64'(done_early), 64'd0);
      checkOutput({tag, "_hold"}, 64'(hold_bad), 64'd0);
      checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
      @(negedge clock);
      checkOutput({tag, "_done_off"}, 64'(done), 64'd0);
      checkOutput({tag, "_busy_off"}, 64'(busy), 64'd0);
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      op          = 2'b00;
      operand_a   = '0;
      operand_b   = '0;
      hi_write_en = 1'b0;
      lo_write_en = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_hi", 64'(hi), 64'd0);
      checkOutput("reset_lo", 64'(lo), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      reset = 1'b0;

      // MTHI then MTLO in IDLE, then both in one cycle.
      hi_write_en = 1'b1;
      operand_a   = 32'h0000_1234;
      @(negedge clock);
      checkOutput("mthi_done", 64'(done), 64'd0);
      hi_write_en = 1'b0;
      lo_write_en = 1'b1;
      operand_a   = 32'h0000_5678;
      @(negedge clock);
      lo_write_en = 1'b0;
      checkOutput("mtlo_done", 64'(done), 64'd0);
      checkOutput("mt_hi", 64'(hi), 64'h1234);
      checkOutput("mt_lo", 64'(lo), 64'h5678);
      hi_write_en = 1'b1;
      lo_write_en = 1'b1;
      operand_a   = 32'hABCD_0001;
      @(negedge clock);
      hi_write_en = 1'b0;
      lo_write_en = 1'b0;
      checkOutput("mt_both_hi", 64'(hi), 64'hABCD_0001);
      checkOutput("mt_both_lo", 64'(lo), 64'hABCD_0001);
      checkOutput("mt_both_busy", 64'(busy), 64'd0);

      applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                    32'hFFFF_FFFE, 32'h0000_0001);
      applyStimulus("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0,
                    32'hFFFF_FFFF, 32'hFFFF_FFEB);
      applyStimulus("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0,
                    32'h4000_0000, 32'h0000_0000);
      applyStimulus("multu_mix", 2'b01, 32'h8000_0000, 32'd3, 1'b0,
                    32'h0000_0001, 32'h8000_0000);
      applyStimulus("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD);
      applyStimulus("div_7byneg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0,
                    32'h0000_0001, 32'hFFFF_FFFD);
      applyStimulus("divu_100by7", 2'b11, 32'd100, 32'd7, 1'b1,
                    32'd2, 32'd14);
      applyStimulus("divu_5by0", 2'b11, 32'd5, 32'd0, 1'b0,
                    32'd5, 32'hFFFF_FFFF);
      applyStimulus("div_neg5by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0,
                    32'hFFFF_FFFB, 32'hFFFF_FFFF);
      applyStimulus("div_minbyneg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                    1'b0, 32'h0000_0000, 32'h8000_0000);
      applyStimulus("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 1'b0,
                    32'h0000_FFFF, 32'h0000_FFFF);

      // Reset in the middle of a divide: everything clears on the next edge.
      @(negedge clock);
      start     = 1'b1;
      op        = 2'b10;
      operand_a = 32'd1000;
      operand_b = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock);
      checkOutput("mid_div_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midrst_hi", 64'(hi), 64'd0);
      checkOutput("midrst_lo", 64'(lo), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      reset = 1'b0;

      applyStimulus("after_rst_div", 2'b10, 32'd1000, 32'd3, 1'b0,
                    32'd1, 32'd333);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
